// File: rtl/spi_sfr_sequencer.sv
// Byte-stream sequencer for the SPI master SFR ports: configures the master,
// loads each TX byte, polls SPIF, clears it, reads the RX byte back and frames slave-select.
module spi_sfr_sequencer #(
  parameter int TIMEOUT_W = 16,
  parameter int SPIF_BIT  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cfg_spcr,
  input  logic [7:0] cfg_sper,
  input  logic [7:0] cfg_ssn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] sfraddr_w,
  output logic       sfrwe,
  output logic [7:0] spidata_o,
  output logic [2:0] sfraddr_r,
  input  logic [7:0] sfr_data_i,
  output logic [7:0] spssn_o
);

  localparam logic [1:0] ADDR_SPCR = 2'd0;
  localparam logic [1:0] ADDR_SPSR = 2'd1;
  localparam logic [1:0] ADDR_SPDR = 2'd2;
  localparam logic [1:0] ADDR_SPER = 2'd3;
  localparam logic [2:0] RADDR_SPSR = 3'd1;
  localparam logic [2:0] RADDR_SPDR = 3'd2;
  localparam logic [7:0] SPIF_MASK = 8'h01 << SPIF_BIT;
  // Poll count value at which the next failed poll is the last one allowed.
  localparam logic [TIMEOUT_W-1:0] POLL_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    ST_IDLE, ST_CFG_CR, ST_CFG_ER, ST_LOAD, ST_POLL_A, ST_POLL_D,
    ST_CLR, ST_RD_A, ST_RD_D, ST_OUT, ST_END
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMEOUT_W-1:0] poll_cnt;
  logic [TIMEOUT_W-1:0] poll_nxt;
  logic                 last_flag;
  logic                 last_nxt;
  logic [7:0]           sper_lat;
  logic [7:0]           sper_nxt;
  logic                 go_load;
  logic                 tx_ready_nxt;
  logic                 rx_valid_nxt;
  logic [7:0]           rx_data_nxt;
  logic                 timeout_nxt;
  logic                 sfrwe_nxt;
  logic [1:0]           waddr_nxt;
  logic [7:0]           wdata_nxt;
  logic [2:0]           raddr_nxt;
  logic [7:0]           ssn_nxt;

  // Next state plus the output values that belong to that next state.
  always_comb begin
    state_nxt    = state;
    tx_ready_nxt = 1'b0;
    rx_valid_nxt = rx_valid;
    rx_data_nxt  = rx_data;
    timeout_nxt  = timeout_err;
    sfrwe_nxt    = 1'b0;
    waddr_nxt    = 2'd0;
    wdata_nxt    = 8'h00;
    raddr_nxt    = 3'd0;
    ssn_nxt      = spssn_o;
    poll_nxt     = poll_cnt;
    last_nxt     = last_flag;
    sper_nxt     = sper_lat;
    go_load      = 1'b0;
    case (state)
      ST_IDLE: begin
        ssn_nxt = 8'hFF;
        if (tx_valid) begin
          state_nxt   = ST_CFG_CR;
          sper_nxt    = cfg_sper;
          ssn_nxt     = cfg_ssn;
          timeout_nxt = 1'b0;
          sfrwe_nxt   = 1'b1;
          waddr_nxt   = ADDR_SPCR;
          wdata_nxt   = cfg_spcr;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CFG_CR: begin
        state_nxt = ST_CFG_ER;
        sfrwe_nxt = 1'b1;
        waddr_nxt = ADDR_SPER;
        wdata_nxt = sper_lat;
      end
      ST_CFG_ER: go_load = 1'b1;
      ST_LOAD: begin
        state_nxt = ST_POLL_A;
        raddr_nxt = RADDR_SPSR;
      end
      ST_POLL_A: state_nxt = ST_POLL_D;
      ST_POLL_D: begin
        if (sfr_data_i[SPIF_BIT]) begin
          state_nxt = ST_CLR;
          sfrwe_nxt = 1'b1;
          waddr_nxt = ADDR_SPSR;
          wdata_nxt = SPIF_MASK;
        end else if (poll_cnt == POLL_LAST) begin
          poll_nxt    = poll_cnt + TIMEOUT_W'(1);
          timeout_nxt = 1'b1;
          state_nxt   = ST_END;
          ssn_nxt     = 8'hFF;
        end else begin
          poll_nxt  = poll_cnt + TIMEOUT_W'(1);
          state_nxt = ST_POLL_A;
          raddr_nxt = RADDR_SPSR;
        end
      end
      ST_CLR: begin
        state_nxt = ST_RD_A;
        raddr_nxt = RADDR_SPDR;
      end
      ST_RD_A: state_nxt = ST_RD_D;
      ST_RD_D: begin
        state_nxt    = ST_OUT;
        rx_valid_nxt = 1'b1;
        rx_data_nxt  = sfr_data_i;
      end
      ST_OUT: begin
        // With rx_valid low the byte is already delivered; only a new TX byte moves us on.
        if (rx_valid && !rx_ready) begin
          state_nxt = ST_OUT;
        end else begin
          rx_valid_nxt = 1'b0;
          if (rx_valid && last_flag) begin
            state_nxt = ST_END;
            ssn_nxt   = 8'hFF;
          end else if (tx_valid) begin
            go_load = 1'b1;
          end else begin
            state_nxt = ST_OUT;
          end
        end
      end
      ST_END: begin
        state_nxt = ST_IDLE;
        ssn_nxt   = 8'hFF;
      end
      default: begin
        state_nxt    = ST_IDLE;
        ssn_nxt      = 8'hFF;
        rx_valid_nxt = 1'b0;
      end
    endcase
    if (go_load) begin
      state_nxt    = ST_LOAD;
      tx_ready_nxt = 1'b1;
      sfrwe_nxt    = 1'b1;
      waddr_nxt    = ADDR_SPDR;
      wdata_nxt    = tx_data;
      last_nxt     = tx_last;
      poll_nxt     = '0;
    end else begin
      tx_ready_nxt = 1'b0;
    end
  end

  // State, latched frame context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      poll_cnt    <= '0;
      last_flag   <= 1'b0;
      sper_lat    <= 8'h00;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      sfrwe       <= 1'b0;
      sfraddr_w   <= 2'd0;
      spidata_o   <= 8'h00;
      sfraddr_r   <= 3'd0;
      spssn_o     <= 8'hFF;
    end else begin
      state       <= state_nxt;
      poll_cnt    <= poll_nxt;
      last_flag   <= last_nxt;
      sper_lat    <= sper_nxt;
      tx_ready    <= tx_ready_nxt;
      rx_valid    <= rx_valid_nxt;
      rx_data     <= rx_data_nxt;
      busy        <= (state_nxt != ST_IDLE);
      timeout_err <= timeout_nxt;
      sfrwe       <= sfrwe_nxt;
      sfraddr_w   <= waddr_nxt;
      spidata_o   <= wdata_nxt;
      sfraddr_r   <= raddr_nxt;
      spssn_o     <= ssn_nxt;
    end
  end

endmodule

// File: tb/tb_spi_sfr_sequencer.sv
// Self-checking bench for spi_sfr_sequencer: a behavioural SPI-master SFR model
// plus per-frame expectations of SFR writes, RX bytes, poll counts and slave-select.
module tb_spi_sfr_sequencer;
  localparam int TW = 4;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cfg_spcr = 8'h00, cfg_sper = 8'h00, cfg_ssn = 8'hFF;
  logic tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00, sfr_data_i = 8'h00;
  logic tx_ready, rx_valid, busy, timeout_err, sfrwe;
  logic [7:0] rx_data, spidata_o, spssn_o;
  logic [1:0] sfraddr_w;
  logic [2:0] sfraddr_r;

  int n_checks = 0, n_fails = 0;

  // SFR model state and logs
  logic [9:0] wr_log[$], exp_wr[$];
  logic [7:0] rx_log[$], exp_rx[$], ssn_log[$], rxb_src[$];
  int npoll_src[$];
  int polls = 0, exp_polls = 0, cur_np = NEVER, reads = 0, cyc = 0;
  int bad_we = 0, spdr_while_rx = 0, rx_unstable = 0, busy_rise_cyc = 0, first_spdr_cyc = -1;
  bit cleared = 0, hold_prev = 0, prev_busy = 0, rx_rand = 0;
  logic [7:0] cur_rx = 8'h00, held = 8'h00, pend = 8'h00, status_bg = 8'h00, last_ssn = 8'hFF;

  always #5 clk = ~clk;

  spi_sfr_sequencer #(.TIMEOUT_W(TW), .SPIF_BIT(7)) dut (
    .clk(clk), .rst(rst), .cfg_spcr(cfg_spcr), .cfg_sper(cfg_sper), .cfg_ssn(cfg_ssn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy),
    .timeout_err(timeout_err), .sfraddr_w(sfraddr_w), .sfrwe(sfrwe), .spidata_o(spidata_o),
    .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data_i), .spssn_o(spssn_o));

  // Mid-cycle observation: SFR write/read decoding, RX capture and protocol monitors.
  initial begin : sfr_model
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      prev_busy = busy;
      if (spssn_o !== last_ssn) begin ssn_log.push_back(spssn_o); last_ssn = spssn_o; end
      if (sfrwe === 1'b1) begin
        wr_log.push_back({sfraddr_w, spidata_o});
        if (sfraddr_r != 3'd0) bad_we++;
        if (sfraddr_w == 2'd2) begin
          if (first_spdr_cyc < 0) first_spdr_cyc = cyc;
          if (rx_valid) spdr_while_rx++;
          reads = 0; cleared = 0;
          cur_np = (npoll_src.size() > 0) ? npoll_src.pop_front() : NEVER;
          cur_rx = (rxb_src.size() > 0) ? rxb_src.pop_front() : 8'h00;
        end else if (sfraddr_w == 2'd1 && spidata_o[7]) begin
          cleared = 1;
        end
      end
      if (sfraddr_r == 3'd1) begin
        polls++; reads++;
        pend = (reads >= cur_np && !cleared) ? (status_bg | 8'h80) : (status_bg & 8'h7F);
      end else if (sfraddr_r == 3'd2) begin
        pend = cur_rx;
      end else begin
        pend = 8'($urandom);
      end
      if (rx_valid === 1'b1 && rx_ready) rx_log.push_back(rx_data);
      if (hold_prev && rx_valid && rx_data !== held) rx_unstable++;
      hold_prev = rx_valid && !rx_ready;
      held = rx_data;
    end
  end

  // Read data appears one cycle after the read address.
  initial begin : sfr_drive
    forever begin @(posedge clk); #1; sfr_data_i = pend; end
  end

  initial begin : rx_random_ready
    forever begin @(posedge clk); #1; if (rx_rand) rx_ready = 1'($urandom_range(0, 1)); end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got still running, required finished");
    $fatal(1);
  end

  task automatic clear_logs();
    wr_log.delete(); exp_wr.delete(); rx_log.delete(); exp_rx.delete(); ssn_log.delete();
    npoll_src.delete(); rxb_src.delete();
    polls = 0; exp_polls = 0; bad_we = 0; spdr_while_rx = 0; rx_unstable = 0; first_spdr_cyc = -1;
  endtask

  task automatic plan_cfg(input logic [7:0] spcr, input logic [7:0] sper);
    exp_wr.push_back({2'd0, spcr});
    exp_wr.push_back({2'd3, sper});
  endtask

  // A byte either completes after np polls (CLR write + RX byte) or times out after 2**TW-1 polls.
  task automatic plan_byte(input logic [7:0] b, input int np, input logic [7:0] rb);
    exp_wr.push_back({2'd2, b});
    npoll_src.push_back(np);
    rxb_src.push_back(rb);
    if (np <= (2 ** TW) - 1) begin
      exp_wr.push_back({2'd1, 8'h80});
      exp_rx.push_back(rb);
      exp_polls += np;
    end else begin
      exp_polls += (2 ** TW) - 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = tx_ready; end
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL tx_accept: byte %h got tx_ready=0, required 1", d); end
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin @(negedge clk); done = !busy; end
    n_checks++;
    if (!done) begin n_fails++; $display("FAIL wait_idle: got busy=1, required 0"); end
  endtask

  task automatic test_reset();
    bit seen = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_ready, rx_valid, busy, timeout_err, sfrwe} !== 5'b0) begin
      n_fails++; $display("FAIL reset_flags: got %b, required 00000", {tx_ready, rx_valid, busy, timeout_err, sfrwe});
    end
    n_checks++;
    if ({rx_data, spidata_o, sfraddr_w, sfraddr_r, spssn_o} !== {21'h0, 8'hFF}) begin
      n_fails++; $display("FAIL reset_data: got %h/%h/%h/%h/%h, required 0/0/0/0/ff", rx_data, spidata_o, sfraddr_w, sfraddr_r, spssn_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    clear_logs();
    cfg_spcr = 8'h51; cfg_sper = 8'h02; cfg_ssn = 8'hFE;
    npoll_src.push_back(NEVER);
    send_byte(8'h99, 1'b1);
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = (polls >= 3); end
    n_checks++;
    if (!seen) begin n_fails++; $display("FAIL reset_reach_poll: got %0d polls, required 3", polls); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (spssn_o !== 8'hFF || busy !== 1'b0 || sfraddr_r !== 3'd0) begin
      n_fails++; $display("FAIL reset_mid_poll: got ssn=%h busy=%b raddr=%0d, required ff 0 0", spssn_o, busy, sfraddr_r);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rx_log.size() != 0 || spssn_o !== 8'hFF) begin
      n_fails++; $display("FAIL reset_after: got busy=%b rx=%0d ssn=%h, required 0 0 ff", busy, rx_log.size(), spssn_o);
    end
  endtask

  task automatic test_single();
    clear_logs();
    cfg_spcr = 8'($urandom); cfg_sper = 8'($urandom); cfg_ssn = 8'($urandom) & 8'hFE;
    status_bg = 8'($urandom);
    plan_cfg(cfg_spcr, cfg_sper);
    plan_byte(8'hA5, 5, 8'h3C);
    send_byte(8'hA5, 1'b1);
    wait_idle();
    n_checks++;
    if (wr_log.size() != exp_wr.size()) begin n_fails++; $display("FAIL single_wr_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < wr_log.size()) begin
      n_checks++;
      if (wr_log[i] !== exp_wr[i]) begin n_fails++; $display("FAIL single_wr[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
    end
    n_checks++;
    if (rx_log.size() != 1 || rx_log[0] !== 8'h3C) begin n_fails++; $display("FAIL single_rx: got %0d bytes, required one 3c", rx_log.size()); end
    n_checks++;
    if (polls != 5) begin n_fails++; $display("FAIL single_polls: got %0d, required 5", polls); end
    n_checks++;
    if (ssn_log.size() != 2 || ssn_log[0] !== cfg_ssn || ssn_log[1] !== 8'hFF) begin
      n_fails++; $display("FAIL single_ssn: got %0d changes, required %h then ff", ssn_log.size(), cfg_ssn);
    end
    n_checks++;
    if (first_spdr_cyc - busy_rise_cyc != 2) begin n_fails++; $display("FAIL single_latency: got %0d, required 2", first_spdr_cyc - busy_rise_cyc); end
    n_checks++;
    if (timeout_err !== 1'b0 || bad_we != 0) begin n_fails++; $display("FAIL single_flags: got timeout=%b bad_we=%0d, required 0 0", timeout_err, bad_we); end
  endtask

  task automatic test_burst();
    logic [7:0] bytes[3] = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    cfg_spcr = 8'($urandom); cfg_sper = 8'($urandom); cfg_ssn = 8'($urandom) & 8'hFE;
    status_bg = 8'($urandom);
    plan_cfg(cfg_spcr, cfg_sper);
    foreach (bytes[i]) plan_byte(bytes[i], int'($urandom_range(1, 6)), 8'($urandom));
    foreach (bytes[i]) send_byte(bytes[i], i == 2);
    wait_idle();
    n_checks++;
    if (wr_log.size() != exp_wr.size()) begin n_fails++; $display("FAIL burst_wr_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < wr_log.size()) begin
      n_checks++;
      if (wr_log[i] !== exp_wr[i]) begin n_fails++; $display("FAIL burst_wr[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
    end
    n_checks++;
    if (rx_log.size() != exp_rx.size()) begin n_fails++; $display("FAIL burst_rx_count: got %0d, required %0d", rx_log.size(), exp_rx.size()); end
    foreach (exp_rx[i]) if (i < rx_log.size()) begin
      n_checks++;
      if (rx_log[i] !== exp_rx[i]) begin n_fails++; $display("FAIL burst_rx[%0d]: got %h, required %h", i, rx_log[i], exp_rx[i]); end
    end
    n_checks++;
    if (polls != exp_polls || ssn_log.size() != 2) begin
      n_fails++; $display("FAIL burst_polls_ssn: got %0d polls %0d ssn changes, required %0d and 2", polls, ssn_log.size(), exp_polls);
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    cfg_spcr = 8'($urandom); cfg_sper = 8'($urandom); cfg_ssn = 8'($urandom) & 8'hFE;
    status_bg = 8'h00;
    plan_cfg(cfg_spcr, cfg_sper);
    plan_byte(8'h5E, 2, 8'hC7);
    plan_byte(8'hE5, 3, 8'h7C);
    rx_ready = 1'b0;
    fork
      begin send_byte(8'h5E, 1'b0); send_byte(8'hE5, 1'b1); end
      begin
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = rx_valid; end
        n_checks++;
        if (!seen) begin n_fails++; $display("FAIL bp_rx_valid: got rx_valid=0, required 1"); end
        repeat (10) @(posedge clk);
        #1; rx_ready = 1'b1;
      end
    join
    wait_idle();
    n_checks++;
    if (rx_unstable != 0 || spdr_while_rx != 0) begin
      n_fails++; $display("FAIL bp_hold: got %0d unstable %0d early writes, required 0 0", rx_unstable, spdr_while_rx);
    end
    n_checks++;
    if (wr_log.size() != exp_wr.size()) begin n_fails++; $display("FAIL bp_wr_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < wr_log.size()) begin
      n_checks++;
      if (wr_log[i] !== exp_wr[i]) begin n_fails++; $display("FAIL bp_wr[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
    end
    n_checks++;
    if (rx_log.size() != 2 || rx_log[0] !== 8'hC7 || rx_log[1] !== 8'h7C) begin
      n_fails++; $display("FAIL bp_rx: got %0d bytes, required c7 7c", rx_log.size());
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    cfg_spcr = 8'($urandom); cfg_sper = 8'($urandom); cfg_ssn = 8'($urandom) & 8'hFE;
    status_bg = 8'($urandom);
    plan_cfg(cfg_spcr, cfg_sper);
    plan_byte(8'h42, NEVER, 8'h00);
    send_byte(8'h42, 1'b1);
    wait_idle();
    n_checks++;
    if (polls != exp_polls) begin n_fails++; $display("FAIL to_polls: got %0d, required %0d", polls, exp_polls); end
    n_checks++;
    if (timeout_err !== 1'b1 || rx_log.size() != 0 || spssn_o !== 8'hFF) begin
      n_fails++; $display("FAIL to_state: got err=%b rx=%0d ssn=%h, required 1 0 ff", timeout_err, rx_log.size(), spssn_o);
    end
    n_checks++;
    if (wr_log.size() != 3 || wr_log[2] !== exp_wr[2]) begin n_fails++; $display("FAIL to_writes: got %0d writes, required 3 ending %h", wr_log.size(), exp_wr[2]); end
    clear_logs();
    plan_cfg(cfg_spcr, cfg_sper);
    plan_byte(8'h24, 2, 8'h81);
    fork
      send_byte(8'h24, 1'b1);
      begin
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = busy; end
        n_checks++;
        if (!seen || timeout_err !== 1'b0) begin n_fails++; $display("FAIL to_clear: got busy=%b err=%b, required 1 0", seen, timeout_err); end
      end
    join
    wait_idle();
    n_checks++;
    if (rx_log.size() != 1 || rx_log[0] !== 8'h81 || timeout_err !== 1'b0) begin
      n_fails++; $display("FAIL to_next_frame: got %0d rx err=%b, required one 81 err 0", rx_log.size(), timeout_err);
    end
  endtask

  task automatic test_status_noise();
    clear_logs();
    cfg_spcr = 8'($urandom); cfg_sper = 8'($urandom); cfg_ssn = 8'($urandom) & 8'hFE;
    status_bg = 8'h7F;
    plan_cfg(cfg_spcr, cfg_sper);
    plan_byte(8'h6B, 8, 8'hD4);
    send_byte(8'h6B, 1'b1);
    wait_idle();
    n_checks++;
    if (polls != 8) begin n_fails++; $display("FAIL noise_polls: got %0d, required 8", polls); end
    n_checks++;
    if (wr_log.size() != exp_wr.size()) begin n_fails++; $display("FAIL noise_wr_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < wr_log.size()) begin
      n_checks++;
      if (wr_log[i] !== exp_wr[i]) begin n_fails++; $display("FAIL noise_wr[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
    end
    n_checks++;
    if (rx_log.size() != 1 || rx_log[0] !== 8'hD4 || timeout_err !== 1'b0) begin
      n_fails++; $display("FAIL noise_rx: got %0d bytes err=%b, required one d4 err 0", rx_log.size(), timeout_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ssn[$];
    clear_logs();
    status_bg = 8'($urandom);
    rx_rand = 1;
    for (int f = 0; f < 4; f++) begin
      int n = int'($urandom_range(1, 4));
      logic [7:0] b[$];
      cfg_spcr = 8'($urandom); cfg_sper = 8'($urandom); cfg_ssn = 8'($urandom) & 8'hFE;
      plan_cfg(cfg_spcr, cfg_sper);
      exp_ssn.push_back(cfg_ssn);
      exp_ssn.push_back(8'hFF);
      for (int k = 0; k < n; k++) begin
        b.push_back(8'($urandom));
        plan_byte(b[k], int'($urandom_range(1, 6)), 8'($urandom));
      end
      for (int k = 0; k < n; k++) send_byte(b[k], k == n - 1);
    end
    wait_idle();
    rx_rand = 0;
    @(posedge clk); #1; rx_ready = 1'b1;
    n_checks++;
    if (wr_log.size() != exp_wr.size()) begin n_fails++; $display("FAIL b2b_wr_count: got %0d, required %0d", wr_log.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < wr_log.size()) begin
      n_checks++;
      if (wr_log[i] !== exp_wr[i]) begin n_fails++; $display("FAIL b2b_wr[%0d]: got %h, required %h", i, wr_log[i], exp_wr[i]); end
    end
    n_checks++;
    if (rx_log.size() != exp_rx.size()) begin n_fails++; $display("FAIL b2b_rx_count: got %0d, required %0d", rx_log.size(), exp_rx.size()); end
    foreach (exp_rx[i]) if (i < rx_log.size()) begin
      n_checks++;
      if (rx_log[i] !== exp_rx[i]) begin n_fails++; $display("FAIL b2b_rx[%0d]: got %h, required %h", i, rx_log[i], exp_rx[i]); end
    end
    n_checks++;
    if (ssn_log.size() != exp_ssn.size()) begin n_fails++; $display("FAIL b2b_ssn_count: got %0d, required %0d", ssn_log.size(), exp_ssn.size()); end
    foreach (exp_ssn[i]) if (i < ssn_log.size()) begin
      n_checks++;
      if (ssn_log[i] !== exp_ssn[i]) begin n_fails++; $display("FAIL b2b_ssn[%0d]: got %h, required %h", i, ssn_log[i], exp_ssn[i]); end
    end
    n_checks++;
    if (polls != exp_polls || rx_unstable != 0 || bad_we != 0 || spdr_while_rx != 0) begin
      n_fails++; $display("FAIL b2b_protocol: got polls %0d/%0d unstable %0d bad_we %0d early %0d, required equal polls and zeros",
                          polls, exp_polls, rx_unstable, bad_we, spdr_while_rx);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_timeout();
    test_status_noise();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
